// File: rtl/pkt_lane_dispatch_pkg.sv
// Shared definitions for the packet-parser NoC endpoint: module IDs,
// dispatch FSM states and flit field-offset helpers.
package pkt_lane_dispatch_pkg;

    // Destination module IDs carried in the head flit dest_mod field
    typedef enum logic [2:0] {
        mod_none  = 3'd0,
        ipv4_mod  = 3'd1,
        ipv6_mod  = 3'd2,
        arp_mod   = 3'd3,
        other_mod = 3'd4
    } mod_t;

    // Dispatch FSM states
    typedef enum logic [1:0] {
        DISP_IDLE = 2'd0,
        DISP_LANE = 2'd1,
        DISP_DROP = 2'd2
    } dispState_t;

    localparam logic [15:0] DROP_SAT = 16'hFFFF;

    // Bit index of the start-of-packet flag
    function automatic int sopBit(input int width);
        return width - 2;
    endfunction

    // Bit index of the end-of-packet flag inside quarter q (0..3)
    function automatic int eopBit(input int width, input int q);
        return ((q + 1) * width) / 4 - 3;
    endfunction

    // Bit index of the most significant dest_mod bit
    function automatic int destModMsb(input int lsb);
        return lsb + 2;
    endfunction

endpackage

// File: rtl/pkt_lane_dispatch_arb.sv
// Packet-atomic round-robin arbiter for the merge side. Once a lane is
// picked it stays granted until that lane's eop flit is accepted.
module rr_pkt_arbiter
    import pkt_lane_dispatch_pkg::*;
#(
    parameter int N = 2,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  i_req,
    input  logic          i_accept,
    input  logic          i_acceptEop,
    output logic          o_grantValid,
    output logic [IW-1:0] o_grantIdx
);

    logic          r_locked;
    logic [IW-1:0] r_lockIdx;
    logic [IW-1:0] r_ptr;
    logic          w_pickValid;
    logic [IW-1:0] w_pickIdx;
    logic [IW-1:0] w_ptrNext;

    // First requesting lane at or after the round-robin pointer
    always_comb begin
        w_pickValid = 1'b0;
        w_pickIdx   = r_ptr;
        for (int i = 0; i < N; i++) begin
            if (!w_pickValid && i_req[(int'(r_ptr) + i) % N]) begin
                w_pickValid = 1'b1;
                w_pickIdx   = IW'((int'(r_ptr) + i) % N);
            end
        end
    end

    assign w_ptrNext    = (int'(w_pickIdx) == N - 1) ? '0 : w_pickIdx + 1'b1;
    assign o_grantValid = r_locked || w_pickValid;
    assign o_grantIdx   = r_locked ? r_lockIdx : w_pickIdx;

    // Lock onto a new pick, release when the locked lane's eop is taken
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_locked  <= 1'b0;
            r_lockIdx <= '0;
            r_ptr     <= '0;
        end else if (!r_locked) begin
            if (w_pickValid) begin
                r_lockIdx <= w_pickIdx;
                r_ptr     <= w_ptrNext;
                r_locked  <= !(i_accept && i_acceptEop);
            end
        end else if (i_accept && i_acceptEop) begin
            r_locked <= 1'b0;
        end
    end

endmodule

// File: rtl/pkt_lane_dispatch_fifo.sv
// Show-ahead lane FIFO with a registered empty flag. The empty flag
// clears one cycle after the first write but sets in the same edge as
// the pop that drains the last entry, so the head is never stale.
module fifo_emptyw
    import pkt_lane_dispatch_pkg::*;
#(
    parameter int WIDTH = 600,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_sclr,
    input  logic             i_wrreq,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_rdreq,
    output logic [WIDTH-1:0] o_q,
    output logic             o_empty,
    output logic [AW:0]      o_usedw
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [AW:0]      r_count;
    logic [AW:0]      w_countNext;
    logic             r_empty;
    logic             w_pop;

    assign w_pop   = i_rdreq && !r_empty;
    assign o_empty = r_empty;
    assign o_usedw = r_count;
    assign o_q     = r_empty ? '0 : r_mem[r_rdPtr];

    // Occupancy after this cycle's push and pop
    always_comb begin
        w_countNext = r_count;
        case ({i_wrreq, w_pop})
            2'b10:   w_countNext = r_count + 1'b1;
            2'b01:   w_countNext = r_count - 1'b1;
            default: w_countNext = r_count;
        endcase
    end

    // Pointer, occupancy and empty-flag registers
    always_ff @(posedge clk) begin
        if (i_sclr) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            r_empty <= 1'b1;
        end else begin
            if (i_wrreq) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            r_count <= w_countNext;
            r_empty <= (w_countNext == '0) || (r_count == '0);
        end
    end

    // Storage array, not reset; the head is masked while empty
    always_ff @(posedge clk) begin
        if (i_wrreq) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

endmodule

// File: rtl/pkt_lane_dispatch.sv
// Dispatch/merge shell: routes whole packets by head-flit dest_mod into
// per-lane FIFOs, drops unmatched packets, and merges lane results onto
// one output through a packet-atomic round-robin arbiter.
module pkt_lane_dispatch
    import pkt_lane_dispatch_pkg::*;
#(
    parameter int         NOC_WIDTH  = 600,
    parameter int         NUM_LANES  = 2,
    parameter int         FIFO_DEPTH = 8,
    parameter int         MOD_LSB    = 510,
    parameter logic [2:0] LANE_MOD [NUM_LANES] = '{3'd1, 3'd2},
    localparam int        LANE_W     = $clog2(NUM_LANES),
    localparam int        CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NOC_WIDTH-1:0]           i_data_in,
    input  logic                           i_valid_in,
    output logic                           i_ready_out,
    output logic [NUM_LANES*NOC_WIDTH-1:0] lane_data_out,
    output logic [NUM_LANES-1:0]           lane_valid_out,
    input  logic [NUM_LANES-1:0]           lane_ready_in,
    input  logic [NUM_LANES*NOC_WIDTH-1:0] res_data_in,
    input  logic [NUM_LANES-1:0]           res_valid_in,
    output logic [NUM_LANES-1:0]           res_ready_out,
    output logic [NOC_WIDTH-1:0]           o_data_out,
    output logic                           o_valid_out,
    input  logic                           o_ready_in,
    output logic [15:0]                    drop_count
);

    function automatic logic flitEop(input logic [NOC_WIDTH-1:0] f);
        logic e;
        e = 1'b0;
        for (int q = 0; q < 4; q++) begin
            e = e | f[eopBit(NOC_WIDTH, q)];
        end
        return e;
    endfunction

    dispState_t            r_state;
    dispState_t            w_stateNext;
    logic [LANE_W-1:0]     r_cur;
    logic [LANE_W-1:0]     w_curNext;
    logic [15:0]           r_dropCount;
    logic                  r_readyEn;
    logic                  w_accept;
    logic                  w_sop;
    logic                  w_eop;
    logic [2:0]            w_destMod;
    logic                  w_match;
    logic [LANE_W-1:0]     w_matchIdx;
    logic                  w_dropInc;
    logic [NUM_LANES-1:0]  w_push;
    logic [NUM_LANES-1:0]  w_empty;
    logic [NUM_LANES-1:0]  w_roomOk;
    logic [CNT_W-1:0]      w_usedw [NUM_LANES];

    logic                  w_grantValid;
    logic [LANE_W-1:0]     w_grantIdx;
    logic [NOC_WIDTH-1:0]  w_resData;
    logic                  w_resAccept;
    logic                  w_resEop;
    logic                  w_outFree;
    logic                  r_oValid;
    logic [NOC_WIDTH-1:0]  r_oData;

    assign w_sop     = i_data_in[sopBit(NOC_WIDTH)];
    assign w_eop     = flitEop(i_data_in);
    assign w_destMod = i_data_in[destModMsb(MOD_LSB):MOD_LSB];
    assign w_accept  = i_valid_in && i_ready_out;

    // Lane lookup: first lane whose module ID equals dest_mod
    always_comb begin
        w_match    = 1'b0;
        w_matchIdx = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (!w_match && (w_destMod == LANE_MOD[k])) begin
                w_match    = 1'b1;
                w_matchIdx = LANE_W'(k);
            end
        end
    end

    // Input is accepted only while every lane keeps two free slots
    always_comb begin
        w_roomOk = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            w_roomOk[k] = (w_usedw[k] <= CNT_W'(FIFO_DEPTH - 2));
        end
    end

    assign i_ready_out = r_readyEn && (&w_roomOk);

    // Dispatch FSM next state, lane writes and drop events
    always_comb begin
        w_stateNext = r_state;
        w_curNext   = r_cur;
        w_push      = '0;
        w_dropInc   = 1'b0;
        if (w_accept) begin
            case (r_state)
                DISP_IDLE: begin
                    if (w_sop) begin
                        if (w_match) begin
                            w_push[w_matchIdx] = 1'b1;
                            w_curNext          = w_matchIdx;
                            if (!w_eop) begin
                                w_stateNext = DISP_LANE;
                            end
                        end else begin
                            w_dropInc = 1'b1;
                            if (!w_eop) begin
                                w_stateNext = DISP_DROP;
                            end
                        end
                    end
                end
                DISP_LANE: begin
                    w_push[r_cur] = 1'b1;
                    if (w_eop) begin
                        w_stateNext = DISP_IDLE;
                    end
                end
                DISP_DROP: begin
                    if (w_eop) begin
                        w_stateNext = DISP_IDLE;
                    end
                end
                default: w_stateNext = DISP_IDLE;
            endcase
        end
    end

    // Dispatch state, current lane, drop counter and ready enable
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= DISP_IDLE;
            r_cur       <= '0;
            r_dropCount <= '0;
            r_readyEn   <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_cur     <= w_curNext;
            r_readyEn <= 1'b1;
            if (w_dropInc && (r_dropCount != DROP_SAT)) begin
                r_dropCount <= r_dropCount + 16'd1;
            end
        end
    end

    assign drop_count = r_dropCount;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        fifo_emptyw #(
            .WIDTH (NOC_WIDTH),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .i_sclr  (!reset),
            .i_wrreq (w_push[k]),
            .i_data  (i_data_in),
            .i_rdreq (lane_ready_in[k]),
            .o_q     (lane_data_out[k*NOC_WIDTH +: NOC_WIDTH]),
            .o_empty (w_empty[k]),
            .o_usedw (w_usedw[k])
        );
    end

    assign lane_valid_out = ~w_empty;

    rr_pkt_arbiter #(
        .N (NUM_LANES)
    ) u_arb (
        .clk          (clk),
        .reset        (reset),
        .i_req        (res_valid_in),
        .i_accept     (w_resAccept),
        .i_acceptEop  (w_resEop),
        .o_grantValid (w_grantValid),
        .o_grantIdx   (w_grantIdx)
    );

    assign w_outFree = !r_oValid || o_ready_in;
    assign w_resData = res_data_in[w_grantIdx*NOC_WIDTH +: NOC_WIDTH];
    assign w_resEop  = flitEop(w_resData);

    // Only the granted lane sees ready, and only when the output can take it
    always_comb begin
        res_ready_out = '0;
        if (w_grantValid && w_outFree) begin
            res_ready_out[w_grantIdx] = 1'b1;
        end
    end

    assign w_resAccept = |(res_ready_out & res_valid_in);

    // Output register: load on accept, hold while stalled
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_oValid <= 1'b0;
            r_oData  <= '0;
        end else if (w_resAccept) begin
            r_oValid <= 1'b1;
            r_oData  <= w_resData;
        end else if (o_ready_in) begin
            r_oValid <= 1'b0;
        end
    end

    assign o_valid_out = r_oValid;
    assign o_data_out  = r_oData;

endmodule

// File: tb/tb_pkt_lane_dispatch.sv
// Self-checking bench for pkt_lane_dispatch with default parameters:
// 600-bit flits, lanes serving dest_mod 1 and 2, 8-deep lane FIFOs.
module tb_pkt_lane_dispatch;

    localparam int NW    = 600;
    localparam int NL    = 2;
    localparam int DEPTH = 8;

    typedef struct {
        logic        sop;
        int          eopQ;
        logic [2:0]  dest;
        logic [31:0] tag;
        logic [1:0]  expValid;
        logic [15:0] expDrop;
    } vec_t;

    logic               clk;
    logic               reset;
    logic [NW-1:0]      i_data_in;
    logic               i_valid_in;
    logic               i_ready_out;
    logic [NL*NW-1:0]   lane_data_out;
    logic [NL-1:0]      lane_valid_out;
    logic [NL-1:0]      lane_ready_in;
    logic [NL*NW-1:0]   res_data_in;
    logic [NL-1:0]      res_valid_in;
    logic [NL-1:0]      res_ready_out;
    logic [NW-1:0]      o_data_out;
    logic               o_valid_out;
    logic               o_ready_in;
    logic [15:0]        drop_count;

    int checks;
    int failures;

    vec_t          vecs [10];
    logic [NW-1:0] flitA [3];
    logic [NW-1:0] flitB [7];
    logic [NW-1:0] resPkt [2][4];
    logic [NW-1:0] expOut [8];
    logic [NW-1:0] flitD [5];
    logic [NW-1:0] flitE [8];
    logic [NW-1:0] laneQ0 [$];
    logic [NW-1:0] laneQ1 [$];
    logic [NW-1:0] tmpFlit;
    logic [NW-1:0] held;
    logic          stalled;
    logic [NL-1:0] accepted;
    int            ridx [2];
    int            outCnt;

    pkt_lane_dispatch dut (
        .clk            (clk),
        .reset          (reset),
        .i_data_in      (i_data_in),
        .i_valid_in     (i_valid_in),
        .i_ready_out    (i_ready_out),
        .lane_data_out  (lane_data_out),
        .lane_valid_out (lane_valid_out),
        .lane_ready_in  (lane_ready_in),
        .res_data_in    (res_data_in),
        .res_valid_in   (res_valid_in),
        .res_ready_out  (res_ready_out),
        .o_data_out     (o_data_out),
        .o_valid_out    (o_valid_out),
        .o_ready_in     (o_ready_in),
        .drop_count     (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flit builder using absolute bit positions for the 600-bit format
    function automatic logic [NW-1:0] mkFlit(input logic sop, input int eopQ,
                                             input logic [2:0] dest, input logic [31:0] tag);
        logic [NW-1:0] f;
        f = '0;
        f[31:0] = tag;
        f[512:510] = dest;
        f[598] = sop;
        if (eopQ >= 0) begin
            f[(eopQ + 1) * 150 - 3] = 1'b1;
        end
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [NW-1:0] actual,
                               input logic [NW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkSmall(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
        checkOutput(name, NW'(actual), NW'(expected));
    endtask

    task automatic applyStimulus(input vec_t v);
        i_data_in  = mkFlit(v.sop, v.eopQ, v.dest, v.tag);
        i_valid_in = 1'b1;
        tick();
        i_valid_in = 1'b0;
        i_data_in  = '0;
        tick();
    endtask

    // Any write into a full lane FIFO is an error
    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NL; k++) begin
                if (dut.w_push[k] && (dut.w_usedw[k] == 4'd8)) begin
                    failures++;
                    $display("[TB] FAIL fifo_overflow lane %0d: write while usedw=8", k);
                end
            end
        end
    end

    // Global time limit
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        checks   = 0;
        failures = 0;

        vecs[0] = '{1'b1,  0, 3'd1, 32'h101, 2'b01, 16'd0};
        vecs[1] = '{1'b1,  1, 3'd2, 32'h102, 2'b10, 16'd0};
        vecs[2] = '{1'b1,  2, 3'd5, 32'h103, 2'b00, 16'd1};
        vecs[3] = '{1'b1,  3, 3'd1, 32'h104, 2'b01, 16'd1};
        vecs[4] = '{1'b0,  0, 3'd1, 32'h105, 2'b00, 16'd1};
        vecs[5] = '{1'b1,  0, 3'd5, 32'h106, 2'b00, 16'd2};
        vecs[6] = '{1'b1,  2, 3'd2, 32'h107, 2'b10, 16'd2};
        vecs[7] = '{1'b1,  0, 3'd0, 32'h108, 2'b00, 16'd3};
        vecs[8] = '{1'b1,  3, 3'd7, 32'h109, 2'b00, 16'd4};
        vecs[9] = '{1'b1,  1, 3'd1, 32'h10A, 2'b01, 16'd4};

        reset         = 1'b0;
        i_data_in     = '0;
        i_valid_in    = 1'b0;
        lane_ready_in = '0;
        res_data_in   = '0;
        res_valid_in  = '0;
        o_ready_in    = 1'b0;
        tick();
        tick();

        $display("[TB] reset state");
        checkSmall("rst_lane_valid", 32'(lane_valid_out), 32'd0);
        checkOutput("rst_lane0_data", lane_data_out[0 +: NW], '0);
        checkOutput("rst_lane1_data", lane_data_out[NW +: NW], '0);
        checkSmall("rst_o_valid", 32'(o_valid_out), 32'd0);
        checkOutput("rst_o_data", o_data_out, '0);
        checkSmall("rst_drop", 32'(drop_count), 32'd0);
        checkSmall("rst_res_ready", 32'(res_ready_out), 32'd0);
        reset = 1'b1;
        tick();
        checkSmall("rst_i_ready_after", 32'(i_ready_out), 32'd1);

        $display("[TB] single-flit vector table");
        for (int v = 0; v < 10; v++) begin
            applyStimulus(vecs[v]);
            tmpFlit = mkFlit(vecs[v].sop, vecs[v].eopQ, vecs[v].dest, vecs[v].tag);
            checkSmall($sformatf("vec%0d_lane_valid", v), 32'(lane_valid_out), 32'(vecs[v].expValid));
            checkOutput($sformatf("vec%0d_lane0_data", v), lane_data_out[0 +: NW],
                        vecs[v].expValid[0] ? tmpFlit : '0);
            checkOutput($sformatf("vec%0d_lane1_data", v), lane_data_out[NW +: NW],
                        vecs[v].expValid[1] ? tmpFlit : '0);
            checkSmall($sformatf("vec%0d_drop", v), 32'(drop_count), 32'(vecs[v].expDrop));
            lane_ready_in = vecs[v].expValid;
            tick();
            lane_ready_in = '0;
        end

        $display("[TB] 3-flit packet to dest 2");
        flitA[0] = mkFlit(1'b1, -1, 3'd2, 32'hA0);
        flitA[1] = mkFlit(1'b1, -1, 3'd5, 32'hA1);
        flitA[2] = mkFlit(1'b0,  1, 3'd0, 32'hA2);
        i_valid_in = 1'b1;
        i_data_in  = flitA[0];
        tick();
        checkSmall("A_valid_first_edge", 32'(lane_valid_out), 32'd0);
        i_data_in = flitA[1];
        tick();
        checkSmall("A_valid_second_edge", 32'(lane_valid_out), 32'b10);
        checkOutput("A_head_first", lane_data_out[NW +: NW], flitA[0]);
        i_data_in = flitA[2];
        tick();
        i_valid_in = 1'b0;
        i_data_in  = '0;
        lane_ready_in = 2'b10;
        for (int i = 0; i < 3; i++) begin
            checkSmall($sformatf("A_pop%0d_valid", i), 32'(lane_valid_out), 32'b10);
            checkOutput($sformatf("A_pop%0d_data", i), lane_data_out[NW +: NW], flitA[i]);
            tick();
        end
        lane_ready_in = '0;
        checkSmall("A_drained", 32'(lane_valid_out), 32'd0);
        checkSmall("A_drop", 32'(drop_count), 32'd4);

        $display("[TB] lane 0 backpressure");
        for (int i = 0; i < 7; i++) begin
            flitB[i] = mkFlit(i == 0, (i == 6) ? 3 : -1, (i == 0) ? 3'd1 : 3'd0, 32'hB0 + i);
        end
        for (int i = 0; i < 7; i++) begin
            i_valid_in = 1'b1;
            i_data_in  = flitB[i];
            #1;
            checkSmall($sformatf("B_ready_before%0d", i), 32'(i_ready_out), 32'd1);
            tick();
        end
        checkSmall("B_ready_full", 32'(i_ready_out), 32'd0);
        i_data_in = mkFlit(1'b1, 0, 3'd2, 32'hBF);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkSmall($sformatf("B_ready_hold%0d", i), 32'(i_ready_out), 32'd0);
        end
        i_valid_in = 1'b0;
        i_data_in  = '0;
        checkSmall("B_lane1_untouched", 32'(lane_valid_out), 32'b01);
        lane_ready_in = 2'b01;
        for (int i = 0; i < 7; i++) begin
            checkSmall($sformatf("B_pop%0d_valid", i), 32'(lane_valid_out[0]), 32'd1);
            checkOutput($sformatf("B_pop%0d_data", i), lane_data_out[0 +: NW], flitB[i]);
            tick();
        end
        lane_ready_in = '0;
        checkSmall("B_drained", 32'(lane_valid_out), 32'd0);
        checkSmall("B_ready_again", 32'(i_ready_out), 32'd1);

        $display("[TB] merge with toggling downstream ready");
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) begin
                resPkt[k][i] = mkFlit(i == 0, (i == 3) ? 0 : -1, 3'd0, 32'hC0 + k * 16 + i);
                expOut[k * 4 + i] = resPkt[k][i];
            end
        end
        ridx[0] = 0;
        ridx[1] = 0;
        outCnt  = 0;
        for (int c = 0; c < 60 && outCnt < 8; c++) begin
            for (int k = 0; k < 2; k++) begin
                res_valid_in[k] = (ridx[k] < 4);
                if (ridx[k] < 4) begin
                    res_data_in[k*NW +: NW] = resPkt[k][ridx[k]];
                end else begin
                    res_data_in[k*NW +: NW] = '0;
                end
            end
            o_ready_in = ((c % 2) == 0);
            #1;
            if (o_valid_out && o_ready_in) begin
                checkOutput($sformatf("merge_out%0d", outCnt), o_data_out, expOut[outCnt]);
                outCnt++;
            end
            stalled  = o_valid_out && !o_ready_in;
            held     = o_data_out;
            accepted = res_valid_in & res_ready_out;
            tick();
            for (int k = 0; k < 2; k++) begin
                if (accepted[k]) begin
                    ridx[k]++;
                end
            end
            if (stalled) begin
                checkSmall("merge_stall_valid", 32'(o_valid_out), 32'd1);
                checkOutput("merge_stall_data", o_data_out, held);
            end
        end
        checkSmall("merge_count", outCnt, 8);
        res_valid_in = '0;
        res_data_in  = '0;
        o_ready_in   = 1'b1;
        tick();

        $display("[TB] reset in the middle of a packet");
        for (int i = 0; i < 5; i++) begin
            flitD[i] = mkFlit(i == 0, (i == 4) ? 0 : -1, (i == 0) ? 3'd1 : 3'd0, 32'hD0 + i);
        end
        o_ready_in   = 1'b0;
        i_valid_in   = 1'b1;
        i_data_in    = flitD[0];
        res_valid_in = 2'b01;
        res_data_in[0 +: NW] = mkFlit(1'b1, -1, 3'd0, 32'hDD);
        tick();
        res_valid_in = '0;
        res_data_in  = '0;
        i_data_in    = flitD[1];
        tick();
        checkSmall("D_pre_o_valid", 32'(o_valid_out), 32'd1);
        i_valid_in = 1'b0;
        i_data_in  = '0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checkSmall("D_lane_valid", 32'(lane_valid_out), 32'd0);
        checkOutput("D_lane0_data", lane_data_out[0 +: NW], '0);
        checkOutput("D_lane1_data", lane_data_out[NW +: NW], '0);
        checkSmall("D_o_valid", 32'(o_valid_out), 32'd0);
        checkOutput("D_o_data", o_data_out, '0);
        checkSmall("D_drop", 32'(drop_count), 32'd0);
        checkSmall("D_res_ready", 32'(res_ready_out), 32'd0);
        tick();
        checkSmall("D_i_ready", 32'(i_ready_out), 32'd1);
        for (int i = 2; i < 5; i++) begin
            i_valid_in = 1'b1;
            i_data_in  = flitD[i];
            tick();
        end
        i_valid_in = 1'b0;
        i_data_in  = '0;
        tick();
        checkSmall("D_residual_lane_valid", 32'(lane_valid_out), 32'd0);
        checkSmall("D_residual_drop", 32'(drop_count), 32'd0);
        tmpFlit    = mkFlit(1'b1, 0, 3'd2, 32'hDE);
        i_valid_in = 1'b1;
        i_data_in  = tmpFlit;
        tick();
        i_valid_in = 1'b0;
        i_data_in  = '0;
        tick();
        checkSmall("D_next_lane_valid", 32'(lane_valid_out), 32'b10);
        checkOutput("D_next_lane1_data", lane_data_out[NW +: NW], tmpFlit);
        lane_ready_in = 2'b10;
        tick();
        lane_ready_in = '0;
        tmpFlit = mkFlit(1'b1, 0, 3'd0, 32'hDF);
        res_valid_in = 2'b10;
        res_data_in[NW +: NW] = tmpFlit;
        o_ready_in = 1'b1;
        #1;
        checkSmall("D_arb_unlocked", 32'(res_ready_out), 32'b10);
        tick();
        res_valid_in = '0;
        res_data_in  = '0;
        checkSmall("D_arb_o_valid", 32'(o_valid_out), 32'd1);
        checkOutput("D_arb_o_data", o_data_out, tmpFlit);
        tick();

        $display("[TB] back-to-back alternating single-flit packets");
        for (int i = 0; i < 8; i++) begin
            flitE[i] = mkFlit(1'b1, 0, (i % 2 == 1) ? 3'd2 : 3'd1, 32'hE0 + i);
        end
        lane_ready_in = 2'b11;
        for (int c = 0; c < 14; c++) begin
            if (c < 8) begin
                i_valid_in = 1'b1;
                i_data_in  = flitE[c];
            end else begin
                i_valid_in = 1'b0;
                i_data_in  = '0;
            end
            #1;
            if (c < 8) begin
                checkSmall($sformatf("E_ready%0d", c), 32'(i_ready_out), 32'd1);
            end
            if (lane_valid_out[0]) begin
                laneQ0.push_back(lane_data_out[0 +: NW]);
            end
            if (lane_valid_out[1]) begin
                laneQ1.push_back(lane_data_out[NW +: NW]);
            end
            tick();
        end
        lane_ready_in = '0;
        checkSmall("E_lane0_count", laneQ0.size(), 4);
        checkSmall("E_lane1_count", laneQ1.size(), 4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("E_lane0_flit%0d", i),
                        (i < laneQ0.size()) ? laneQ0[i] : '0, flitE[2 * i]);
            checkOutput($sformatf("E_lane1_flit%0d", i),
                        (i < laneQ1.size()) ? laneQ1[i] : '0, flitE[2 * i + 1]);
        end
        checkSmall("E_drop", 32'(drop_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
